// File: rtl/operand_crossbar_pipe.sv
// operand_crossbar_pipe: per-container ALU operand select (A, B, C) for an RMT
// action stage. Selected operands, metadata and action words are registered
// together behind a 2-entry valid/ready skid buffer. The block also keeps a
// sticky out-of-range index flag and a count of delivered beats.
module operand_crossbar_pipe #(
    parameter int NUM_CONT = 64,
    parameter int CONT_W   = 32,
    parameter int IDX_W    = 6,
    parameter int ACT_LEN  = 64,
    parameter int META_W   = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CONT*CONT_W+META_W-1:0] phv_in,
    input  logic [NUM_CONT*ACT_LEN-1:0]       action_in,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [NUM_CONT*CONT_W-1:0]        out_opa,
    output logic [NUM_CONT*CONT_W-1:0]        out_opb,
    output logic [NUM_CONT*CONT_W-1:0]        out_opc,
    output logic [META_W-1:0]                 out_meta,
    output logic [NUM_CONT*ACT_LEN-1:0]       out_action,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              err_idx,
    output logic [31:0]                       xfer_cnt
);

    localparam int OPS_W    = NUM_CONT * CONT_W;
    localparam int ACTS_W   = NUM_CONT * ACT_LEN;
    localparam int PHV_W    = OPS_W + META_W;
    localparam int BEAT_W   = 3 * OPS_W + META_W + ACTS_W;

    // Beat layout, LSB first: opa, opb, opc, meta, action
    localparam int OPA_LSB  = 0;
    localparam int OPB_LSB  = OPS_W;
    localparam int OPC_LSB  = 2 * OPS_W;
    localparam int META_LSB = 3 * OPS_W;
    localparam int ACT_LSB  = 3 * OPS_W + META_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // True when a container index does not name an existing container
    function automatic logic idx_bad(input logic [IDX_W-1:0] idx);
        return (int'(idx) >= NUM_CONT);
    endfunction

    // Container value at idx, zero when the index is out of range
    function automatic logic [CONT_W-1:0] cont_at(input logic [PHV_W-1:0] phv,
                                                  input logic [IDX_W-1:0] idx);
        logic [CONT_W-1:0] v;
        v = '0;
        if (!idx_bad(idx)) begin
            v = phv[META_W + int'(idx) * CONT_W +: CONT_W];
        end
        return v;
    endfunction

    logic [OPS_W-1:0]  sel_opa;
    logic [OPS_W-1:0]  sel_opb;
    logic              sel_err;
    logic [BEAT_W-1:0] new_beat;

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] out_beat_q, out_beat_d;
    logic [BEAT_W-1:0] skid_beat_q, skid_beat_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              err_idx_q, err_idx_d;
    logic [31:0]       xfer_cnt_q, xfer_cnt_d;
    logic              in_xfer;
    logic              out_xfer;

    // Decode each action word and pick operands A and B from the incoming PHV
    always_comb begin
        logic [ACT_LEN-1:0] aw;
        logic [7:0]         op;
        logic [IDX_W-1:0]   src_a;
        logic [IDX_W-1:0]   src_b;
        sel_opa = '0;
        sel_opb = '0;
        sel_err = 1'b0;
        aw      = '0;
        op      = '0;
        src_a   = '0;
        src_b   = '0;
        for (int unsigned i = 0; i < NUM_CONT; i++) begin
            aw    = action_in[i*ACT_LEN +: ACT_LEN];
            op    = aw[ACT_LEN-1 -: 8];
            src_a = aw[ACT_LEN-9 -: IDX_W];
            src_b = aw[ACT_LEN-9-IDX_W -: IDX_W];
            case (op)
                8'h01, 8'h02, 8'h07, 8'h08, 8'h0B: begin
                    sel_opa[i*CONT_W +: CONT_W] = cont_at(phv_in, src_a);
                    sel_opb[i*CONT_W +: CONT_W] = cont_at(phv_in, src_b);
                    sel_err = sel_err | idx_bad(src_a) | idx_bad(src_b);
                end
                8'h09, 8'h0A: begin
                    sel_opa[i*CONT_W +: CONT_W] = cont_at(phv_in, src_a);
                    sel_opb[i*CONT_W +: CONT_W] = aw[CONT_W-1:0];
                    sel_err = sel_err | idx_bad(src_a);
                end
                8'h0E: begin
                    sel_opb[i*CONT_W +: CONT_W] = aw[CONT_W-1:0];
                end
                default: begin
                    sel_opa[i*CONT_W +: CONT_W] = phv_in[META_W + i*CONT_W +: CONT_W];
                end
            endcase
        end
    end

    assign new_beat = {action_in, phv_in[META_W-1:0], phv_in[PHV_W-1:META_W], sel_opb, sel_opa};

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Skid-buffer occupancy and data movement; handshake outputs are derived
    // from the next state so they come straight out of flops
    always_comb begin
        state_d     = state_q;
        out_beat_d  = out_beat_q;
        skid_beat_d = skid_beat_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d    = ST_ONE;
                    out_beat_d = new_beat;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    out_beat_d = new_beat;
                end else if (in_xfer) begin
                    state_d     = ST_FULL;
                    skid_beat_d = new_beat;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    state_d    = ST_ONE;
                    out_beat_d = skid_beat_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
        err_idx_d   = err_idx_q | (in_xfer & sel_err);
        xfer_cnt_d  = xfer_cnt_q + {31'd0, out_xfer};
    end

    // State and data registers; reset empties both entries at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_beat_q  <= '0;
            skid_beat_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            err_idx_q   <= 1'b0;
            xfer_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_beat_q  <= out_beat_d;
            skid_beat_q <= skid_beat_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            err_idx_q   <= err_idx_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign out_opa    = out_beat_q[OPA_LSB  +: OPS_W];
    assign out_opb    = out_beat_q[OPB_LSB  +: OPS_W];
    assign out_opc    = out_beat_q[OPC_LSB  +: OPS_W];
    assign out_meta   = out_beat_q[META_LSB +: META_W];
    assign out_action = out_beat_q[ACT_LSB  +: ACTS_W];
    assign out_valid  = out_valid_q;
    assign in_ready   = in_ready_q;
    assign err_idx    = err_idx_q;
    assign xfer_cnt   = xfer_cnt_q;

endmodule

// File: tb/tb_operand_crossbar_pipe.sv
// Testbench for operand_crossbar_pipe: directed beats plus a randomized
// back-pressure run checked against an array-based reference model.
module tb_operand_crossbar_pipe;

    localparam int NC     = 64;
    localparam int CW     = 32;
    localparam int IW     = 6;
    localparam int AL     = 64;
    localparam int MW     = 256;
    localparam int OPS_W  = NC * CW;
    localparam int PHV_W  = OPS_W + MW;
    localparam int ACT_W  = NC * AL;

    localparam int NC2    = 48;
    localparam int OPS2_W = NC2 * CW;
    localparam int PHV2_W = OPS2_W + MW;
    localparam int ACT2_W = NC2 * AL;

    typedef struct packed {
        logic [OPS_W-1:0] opa;
        logic [OPS_W-1:0] opb;
        logic [OPS_W-1:0] opc;
        logic [MW-1:0]    meta;
        logic [ACT_W-1:0] act;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;

    logic [PHV_W-1:0]  phv;
    logic [ACT_W-1:0]  act;
    logic              in_valid, in_ready, out_valid, out_ready, err_idx;
    logic [OPS_W-1:0]  out_opa, out_opb, out_opc;
    logic [MW-1:0]     out_meta;
    logic [ACT_W-1:0]  out_action;
    logic [31:0]       xfer_cnt;

    logic [PHV2_W-1:0] phv48;
    logic [ACT2_W-1:0] act48;
    logic              in_valid48, in_ready48, out_valid48, out_ready48, err_idx48;
    logic [OPS2_W-1:0] out_opa48, out_opb48, out_opc48;
    logic [MW-1:0]     out_meta48;
    logic [ACT2_W-1:0] out_action48;
    logic [31:0]       xfer_cnt48;

    beat_t             dut_beat;
    beat_t             q[$];
    beat_t             e, b1, b2;

    int                n_checks = 0;
    int                n_errors = 0;

    operand_crossbar_pipe #(.NUM_CONT(NC), .CONT_W(CW), .IDX_W(IW), .ACT_LEN(AL), .META_W(MW)) u_dut (
        .clk(clk), .rst(rst), .phv_in(phv), .action_in(act), .in_valid(in_valid), .in_ready(in_ready),
        .out_opa(out_opa), .out_opb(out_opb), .out_opc(out_opc), .out_meta(out_meta),
        .out_action(out_action), .out_valid(out_valid), .out_ready(out_ready),
        .err_idx(err_idx), .xfer_cnt(xfer_cnt)
    );

    operand_crossbar_pipe #(.NUM_CONT(NC2), .CONT_W(CW), .IDX_W(IW), .ACT_LEN(AL), .META_W(MW)) u_dut48 (
        .clk(clk), .rst(rst), .phv_in(phv48), .action_in(act48), .in_valid(in_valid48), .in_ready(in_ready48),
        .out_opa(out_opa48), .out_opb(out_opb48), .out_opc(out_opc48), .out_meta(out_meta48),
        .out_action(out_action48), .out_valid(out_valid48), .out_ready(out_ready48),
        .err_idx(err_idx48), .xfer_cnt(xfer_cnt48)
    );

    assign dut_beat = {out_opa, out_opb, out_opc, out_meta, out_action};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compares a wide vector; reports the first differing 64-bit chunk
    task automatic check_wide(input string tag, input logic [4095:0] got, input logic [4095:0] exp);
        int unsigned k;
        logic        found;
        k     = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (!found && (got[64*i +: 64] !== exp[64*i +: 64])) begin
                k     = i;
                found = 1'b1;
            end
        end
        check($sformatf("%s[%0d]", tag, k), got[64*k +: 64], exp[64*k +: 64]);
    endtask

    task automatic check_beat(input string tag, input beat_t x);
        check_wide({tag, ".opa"},  4096'(dut_beat.opa),  4096'(x.opa));
        check_wide({tag, ".opb"},  4096'(dut_beat.opb),  4096'(x.opb));
        check_wide({tag, ".opc"},  4096'(dut_beat.opc),  4096'(x.opc));
        check_wide({tag, ".meta"}, 4096'(dut_beat.meta), 4096'(x.meta));
        check_wide({tag, ".act"},  4096'(dut_beat.act),  4096'(x.act));
    endtask

    function automatic logic [AL-1:0] mk_act(input logic [7:0] op, input logic [5:0] sa,
                                             input logic [5:0] sb, input logic [31:0] imm);
        return {op, sa, sb, 12'd0, imm};
    endfunction

    // Reference model: operand rules applied to an array of containers
    function automatic beat_t predict(input logic [PHV_W-1:0] p, input logic [ACT_W-1:0] a);
        beat_t       b;
        logic [31:0] c [NC];
        logic [63:0] w;
        logic [7:0]  op;
        int unsigned sa, sb;
        logic [31:0] va, vb;
        for (int i = 0; i < NC; i++) c[i] = p[MW + 32*i +: 32];
        b.meta = p[MW-1:0];
        b.act  = a;
        for (int i = 0; i < NC; i++) begin
            w  = a[64*i +: 64];
            op = w[63:56];
            sa = {26'd0, w[55:50]};
            sb = {26'd0, w[49:44]};
            va = '0;
            vb = '0;
            if (op inside {8'h01, 8'h02, 8'h07, 8'h08, 8'h0B}) begin
                va = (sa < NC) ? c[sa] : '0;
                vb = (sb < NC) ? c[sb] : '0;
            end else if (op == 8'h09 || op == 8'h0A) begin
                va = (sa < NC) ? c[sa] : '0;
                vb = w[31:0];
            end else if (op == 8'h0E) begin
                vb = w[31:0];
            end else begin
                va = c[i];
            end
            b.opa[32*i +: 32] = va;
            b.opb[32*i +: 32] = vb;
            b.opc[32*i +: 32] = c[i];
        end
        return b;
    endfunction

    task automatic rand_beat(output logic [PHV_W-1:0] p, output logic [ACT_W-1:0] a);
        logic [7:0]  ops [12];
        logic [31:0] r;
        ops = '{8'h01, 8'h02, 8'h07, 8'h08, 8'h0B, 8'h09, 8'h0A, 8'h0E, 8'h00, 8'h03, 8'h0F, 8'hFF};
        for (int i = 0; i < PHV_W / 32; i++) p[32*i +: 32] = $urandom;
        for (int i = 0; i < NC; i++) begin
            r = $urandom;
            a[64*i +: 64] = {ops[$urandom_range(0, 11)], r[5:0], r[11:6], r[23:12], $urandom};
        end
    endtask

    task automatic std_conts();
        for (int i = 0; i < NC; i++) phv[MW + 32*i +: 32] = 32'h100 + 32'(i);
        for (int i = 0; i < MW / 32; i++) phv[32*i +: 32] = $urandom;
        act = '0;
    endtask

    int  sent, recv, cyc;
    logic acc;

    initial begin
        rst = 1'b1;
        phv = '0; act = '0; in_valid = 1'b0; out_ready = 1'b0;
        phv48 = '0; act48 = '0; in_valid48 = 1'b0; out_ready48 = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_err_idx",   64'(err_idx),   64'd0);
        check("rst_xfer_cnt",  64'(xfer_cnt),  64'd0);
        check_beat("rst_data", '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // T1: all default ops
        std_conts();
        e = predict(phv, act);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_opa5", 64'(out_opa[5*32 +: 32]), 64'h105);
        check("t1_opb5", 64'(out_opb[5*32 +: 32]), 64'h0);
        check("t1_opc5", 64'(out_opc[5*32 +: 32]), 64'h105);
        check_beat("t1", e);
        @(posedge clk); #1;
        check("t1_xfer_cnt",  64'(xfer_cnt),  64'd1);
        check("t1_drained",   64'(out_valid), 64'd0);

        // T2: register/immediate selection
        std_conts();
        act[0*64 +: 64] = mk_act(8'h01, 6'd5, 6'd63, 32'd0);
        act[3*64 +: 64] = mk_act(8'h0A, 6'd2, 6'd0, 32'hDEADBEEF);
        act[7*64 +: 64] = mk_act(8'h0E, 6'd0, 6'd0, 32'd7);
        e = predict(phv, act);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t2_opa0", 64'(out_opa[0*32 +: 32]), 64'h105);
        check("t2_opb0", 64'(out_opb[0*32 +: 32]), 64'h13F);
        check("t2_opa3", 64'(out_opa[3*32 +: 32]), 64'h102);
        check("t2_opb3", 64'(out_opb[3*32 +: 32]), 64'hDEADBEEF);
        check("t2_opa7", 64'(out_opa[7*32 +: 32]), 64'h0);
        check("t2_opb7", 64'(out_opb[7*32 +: 32]), 64'h7);
        check_beat("t2", e);
        @(posedge clk); #1;
        check("t2_xfer_cnt", 64'(xfer_cnt), 64'd2);

        // T3: back-pressure fills the skid buffer
        out_ready = 1'b0;
        rand_beat(phv, act); b1 = predict(phv, act);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("t3_ready_one", 64'(in_ready), 64'd1);
        rand_beat(phv, act); b2 = predict(phv, act);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t3_full_ready", 64'(in_ready),  64'd0);
        check("t3_full_valid", 64'(out_valid), 64'd1);
        check_beat("t3_b1", b1);
        @(posedge clk); #1;
        check_beat("t3_b1_hold", b1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_beat("t3_b2", b2);
        check("t3_ready_back", 64'(in_ready),  64'd1);
        check("t3_b2_valid",   64'(out_valid), 64'd1);
        check("t3_xfer_mid",   64'(xfer_cnt),  64'd3);
        @(posedge clk); #1;
        check("t3_empty",      64'(out_valid), 64'd0);
        check("t3_xfer_cnt",   64'(xfer_cnt),  64'd4);

        // T4: out-of-range index on the 48-container instance
        for (int i = 0; i < NC2; i++) phv48[MW + 32*i +: 32] = 32'h200 + 32'(i);
        act48 = '0;
        act48[2*64 +: 64] = mk_act(8'h01, 6'd50, 6'd1, 32'd0);
        in_valid48 = 1'b1;
        @(posedge clk); #1;
        in_valid48 = 1'b0;
        check("t4_valid", 64'(out_valid48), 64'd1);
        check("t4_opa2",  64'(out_opa48[2*32 +: 32]), 64'h0);
        check("t4_opb2",  64'(out_opb48[2*32 +: 32]), 64'h201);
        check("t4_opc2",  64'(out_opc48[2*32 +: 32]), 64'h202);
        check("t4_opa0",  64'(out_opa48[0*32 +: 32]), 64'h200);
        check("t4_err",   64'(err_idx48), 64'd1);
        act48 = '0;
        in_valid48 = 1'b1;
        @(posedge clk); #1;
        in_valid48 = 1'b0;
        check("t4_clean_opa2", 64'(out_opa48[2*32 +: 32]), 64'h202);
        check("t4_err_sticky", 64'(err_idx48), 64'd1);
        check("t4_main_err",   64'(err_idx),   64'd0);

        // T6: asynchronous reset while full
        out_ready = 1'b0;
        rand_beat(phv, act);
        in_valid = 1'b1;
        @(posedge clk); #1;
        rand_beat(phv, act);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t6_full", 64'(in_ready), 64'd0);
        #3;
        rst = 1'b1;
        #1;
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_in_ready",  64'(in_ready),  64'd1);
        check("t6_xfer_cnt",  64'(xfer_cnt),  64'd0);
        check("t6_err48",     64'(err_idx48), 64'd0);
        check_wide("t6_opa", 4096'(out_opa), '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // T5: 1000 random beats under random back-pressure
        sent = 0; recv = 0; cyc = 0;
        rand_beat(phv, act);
        in_valid = 1'b1;
        while (recv < 1000 && cyc < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            #4;
            if (out_valid && out_ready) begin
                check("t5_q_nonempty", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check_beat($sformatf("t5_beat%0d", recv), e);
                end
                recv++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(predict(phv, act));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (sent < 1000) rand_beat(phv, act);
                else in_valid = 1'b0;
            end
        end
        check("t5_recv",     64'(recv),     64'd1000);
        check("t5_xfer_cnt", 64'(xfer_cnt), 64'd1000);
        check("t5_q_empty",  64'(q.size()), 64'd0);
        check("t5_err",      64'(err_idx),  64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
